// File: rtl/serial_shifter.sv
// Area-lean shifter/rotator: one single-bit shift per clock, result and flags
// returned over a valid/ready handshake.
module serial_shifter #(
    parameter int D_SIZE = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [D_SIZE-1:0]          x_in,
    input  logic [$clog2(D_SIZE)-1:0]  s_in,
    input  logic [2:0]                 op_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [D_SIZE-1:0]          y_out,
    output logic                       zf_out,
    output logic                       vf_out,
    output logic                       valid_out,
    input  logic                       ready_in
);
    localparam int CW = $clog2(D_SIZE);
    localparam logic [CW-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [D_SIZE-1:0] work, step;
    logic [2:0]        op_q;
    logic [CW-1:0]     cnt;
    logic              vf_q, vf_step;

    // One-bit move of the work register for the latched op
    always_comb begin
        step = work;
        casez (op_q)
            3'b000:  step = {1'b0, work[D_SIZE-1:1]};
            3'b001:  step = {work[D_SIZE-1], work[D_SIZE-1:1]};
            3'b01?:  step = {work[0], work[D_SIZE-1:1]};
            3'b100:  step = {work[D_SIZE-2:0], 1'b0};
            3'b101:  step = {work[D_SIZE-2:0], work[0]};
            default: step = {work[D_SIZE-2:0], work[D_SIZE-1]};
        endcase
    end

    // Left shifts overflow when the MSB flips on this step
    assign vf_step = vf_q | ((op_q[2:1] == 2'b10) & (work[D_SIZE-1] ^ work[D_SIZE-2]));

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_in) state_nxt = (s_in != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
            DONE:    if (ready_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state == IDLE);
        valid_out = (state == DONE);
    end

    // Result registers load only on the edge that enters DONE
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            work   <= '0;
            op_q   <= '0;
            cnt    <= '0;
            vf_q   <= 1'b0;
            y_out  <= '0;
            zf_out <= 1'b0;
            vf_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    vf_q <= 1'b0;
                    if (valid_in) begin
                        work <= x_in;
                        op_q <= op_in;
                        cnt  <= s_in;
                        if (s_in == '0) begin
                            y_out  <= x_in;
                            zf_out <= (x_in == '0);
                            vf_out <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - CNT_ONE;
                    vf_q <= vf_step;
                    if (cnt == CNT_ONE) begin
                        y_out  <= step;
                        zf_out <= (step == '0);
                        vf_out <= vf_step;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_shifter.sv
// Directed and random checks of serial_shifter against an arithmetic barrel
// shifter model, including latency, backpressure and reset behaviour.
module tb_serial_shifter;
    localparam int N = 4;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [N-1:0] x_in = '0;
    logic [1:0]   s_in = '0;
    logic [2:0]   op_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_in = 1'b0;
    logic         ready_out, zf_out, vf_out, valid_out;
    logic [N-1:0] y_out;

    int checks = 0;
    int errors = 0;

    serial_shifter #(.D_SIZE(N)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .s_in(s_in), .op_in(op_in),
        .valid_in(valid_in), .ready_out(ready_out), .y_out(y_out), .zf_out(zf_out),
        .vf_out(vf_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk_in = ~clk_in;

    // Combinational barrel shifter, written with plain integer arithmetic
    function automatic int ref_y(input int x, input int s, input int op);
        int mask;
        mask = (1 << N) - 1;
        case (op)
            0: return x >> s;
            1: return (x >> s) | ((((x >> (N - 1)) & 1) != 0) ? ((mask << (N - s)) & mask) : 0);
            2, 3: return ((x >> s) | (x << (N - s))) & mask;
            4: return (x << s) & mask;
            5: return ((x << s) & mask) | (((x & 1) != 0) ? ((1 << s) - 1) : 0);
            default: return ((x << s) | (x >> (N - s))) & mask;
        endcase
    endfunction

    // Left shifts overflow iff the top s+1 operand bits are not all equal
    function automatic int ref_vf(input int x, input int s, input int op);
        int top;
        if ((op != 4 && op != 5) || s == 0) return 0;
        top = x >> (N - 1 - s);
        return (top == 0 || top == (1 << (s + 1)) - 1) ? 0 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Present a request and leave the bench one cycle past the accepting edge
    task automatic send(input int x, input int s, input int op);
        int g;
        g = 0;
        while (!ready_out && g < 50) begin
            tick;
            g++;
        end
        chk("ready_wait", ready_out, 1);
        x_in = N'(x);
        s_in = 2'(s);
        op_in = 3'(op);
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
    endtask

    task automatic collect(input int x, input int s, input int op, input bit rnd);
        int lat, g;
        bit done;
        lat = 1;
        while (!valid_out && lat <= N + 2) begin
            if (rnd) ready_in = 1'($urandom_range(0, 1));
            tick;
            lat++;
        end
        chk("latency", lat, s + 1);
        g = 0;
        done = 0;
        do begin
            chk("y", y_out, ref_y(x, s, op));
            chk("zf", zf_out, (ref_y(x, s, op) == 0) ? 1 : 0);
            chk("vf", vf_out, ref_vf(x, s, op));
            chk("valid_hold", valid_out, 1);
            done = ready_in;
            if (!done) begin
                tick;
                ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                g++;
            end
        end while (!done && g < 30);
        tick;
        chk("valid_drop", valid_out, 0);
        chk("ready_back", ready_out, 1);
    endtask

    initial begin
        int rx, rs, rop;
        logic [N-1:0] hy;
        logic hz, hv;

        rst_in = 1'b1;
        tick;
        tick;
        rst_in = 1'b0;
        chk("rst_ready", ready_out, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_zf", zf_out, 0);
        chk("rst_vf", vf_out, 0);

        ready_in = 1'b1;
        send(4'b1011, 3, 0); collect(4'b1011, 3, 0, 0);
        send(4'b1000, 2, 1); collect(4'b1000, 2, 1, 0);
        send(4'b0001, 1, 2); collect(4'b0001, 1, 2, 0);
        send(4'b1000, 3, 6); collect(4'b1000, 3, 6, 0);
        send(4'b0110, 2, 4); collect(4'b0110, 2, 4, 0);
        send(4'b0011, 2, 5); collect(4'b0011, 2, 5, 0);
        send(4'b0001, 1, 4); collect(4'b0001, 1, 4, 0);
        send(4'b0011, 3, 0); collect(4'b0011, 3, 0, 0);
        for (int op = 0; op < 8; op++) begin
            send(4'b1010, 0, op);
            collect(4'b1010, 0, op, 0);
        end

        // Reset in the middle of a shift drops the request
        send(4'b1011, 3, 0);
        rst_in = 1'b1;
        tick;
        tick;
        rst_in = 1'b0;
        chk("midrst_ready", ready_out, 1);
        chk("midrst_valid", valid_out, 0);
        chk("midrst_y", y_out, 0);
        chk("midrst_zf", zf_out, 0);
        chk("midrst_vf", vf_out, 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("midrst_no_result", valid_out, 0);
        end

        // Backpressure: hold DONE five cycles while a second request waits
        ready_in = 1'b0;
        send(4'b1011, 1, 0);
        for (int i = 0; i < 4 && !valid_out; i++) tick;
        chk("bp_valid", valid_out, 1);
        hy = y_out;
        hz = zf_out;
        hv = vf_out;
        chk("bp_y", hy, 4'b0101);
        x_in = 4'b0011;
        s_in = 2'd2;
        op_in = 3'd5;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_y", y_out, hy);
            chk("bp_hold_zf", zf_out, hz);
            chk("bp_hold_vf", vf_out, hv);
            chk("bp_hold_valid", valid_out, 1);
            chk("bp_not_ready", ready_out, 0);
            tick;
        end
        ready_in = 1'b1;
        tick;
        chk("bp_release_ready", ready_out, 1);
        chk("bp_release_valid", valid_out, 0);
        tick;
        valid_in = 1'b0;
        chk("bp_second_accepted", ready_out, 0);
        collect(4'b0011, 2, 5, 0);

        for (int i = 0; i < 2000; i++) begin
            rx = int'($urandom_range(0, (1 << N) - 1));
            rs = int'($urandom_range(0, N - 1));
            rop = int'($urandom_range(0, 7));
            send(rx, rs, rop);
            collect(rx, rs, rop, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
